// File: rtl/memory_pkg.sv
// Shared types and helpers for the memory-access stage: FSM states,
// one-hot load/store encodings and store lane formatting.
package memory_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam int INFO_W = 11;

   localparam int INFO_LB  = 10;
   localparam int INFO_LH  = 9;
   localparam int INFO_LW  = 8;
   localparam int INFO_LD  = 7;
   localparam int INFO_LBU = 6;
   localparam int INFO_LHU = 5;
   localparam int INFO_LWU = 4;
   localparam int INFO_SB  = 3;
   localparam int INFO_SH  = 2;
   localparam int INFO_SW  = 1;
   localparam int INFO_SD  = 0;

   localparam logic [INFO_W-1:0] OP_LB  = 11'(1) << INFO_LB;
   localparam logic [INFO_W-1:0] OP_LH  = 11'(1) << INFO_LH;
   localparam logic [INFO_W-1:0] OP_LW  = 11'(1) << INFO_LW;
   localparam logic [INFO_W-1:0] OP_LD  = 11'(1) << INFO_LD;
   localparam logic [INFO_W-1:0] OP_LBU = 11'(1) << INFO_LBU;
   localparam logic [INFO_W-1:0] OP_LHU = 11'(1) << INFO_LHU;
   localparam logic [INFO_W-1:0] OP_LWU = 11'(1) << INFO_LWU;
   localparam logic [INFO_W-1:0] OP_SB  = 11'(1) << INFO_SB;
   localparam logic [INFO_W-1:0] OP_SH  = 11'(1) << INFO_SH;
   localparam logic [INFO_W-1:0] OP_SW  = 11'(1) << INFO_SW;
   localparam logic [INFO_W-1:0] OP_SD  = 11'(1) << INFO_SD;

   localparam logic [INFO_W-1:0] MASK_STORE  = OP_SB | OP_SH | OP_SW | OP_SD;
   localparam logic [INFO_W-1:0] MASK_HALF   = OP_LH | OP_LHU | OP_SH;
   localparam logic [INFO_W-1:0] MASK_WORD   = OP_LW | OP_LWU | OP_SW;
   localparam logic [INFO_W-1:0] MASK_DOUBLE = OP_LD | OP_SD;

   function automatic logic is_store(input logic [INFO_W-1:0] info);
      return |(info & MASK_STORE);
   endfunction

   function automatic logic is_misaligned(input logic [INFO_W-1:0] info,
                                          input logic [2:0] addr_lo);
      return ((|(info & MASK_HALF))   && (addr_lo[0] != 1'b0))   ||
             ((|(info & MASK_WORD))   && (addr_lo[1:0] != 2'b00)) ||
             ((|(info & MASK_DOUBLE)) && (addr_lo != 3'b000));
   endfunction

   // Byte enables for the addressed lanes; loads and non-memory ops get none.
   function automatic logic [7:0] store_wstrb(input logic [INFO_W-1:0] info,
                                              input logic [2:0] addr_lo);
      logic [7:0] strb;
      strb = 8'h00;
      if (|(info & OP_SB)) strb = 8'h01 << addr_lo;
      if (|(info & OP_SH)) strb = 8'h03 << addr_lo;
      if (|(info & OP_SW)) strb = 8'h0F << addr_lo;
      if (|(info & OP_SD)) strb = 8'hFF;
      return strb;
   endfunction

   function automatic logic [63:0] store_wdata(input logic [INFO_W-1:0] info,
                                               input logic [63:0] data);
      logic [63:0] wdata;
      wdata = '0;
      if (|(info & OP_SB)) wdata = {8{data[7:0]}};
      if (|(info & OP_SH)) wdata = {4{data[15:0]}};
      if (|(info & OP_SW)) wdata = {2{data[31:0]}};
      if (|(info & OP_SD)) wdata = data;
      return wdata;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Picks the addressed lane out of an aligned doubleword and sign- or
// zero-extends it to 64 bits according to the one-hot load type.
module load_extend
   import memory_pkg::*;
(
   input  logic [INFO_W-1:0] info,
   input  logic [2:0]        addr_lo,
   input  logic [63:0]       rdata,
   output logic [63:0]       result
);

   logic [63:0] shifted;

   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      result  = '0;
      if (|(info & OP_LB))  result = {{56{shifted[7]}},  shifted[7:0]};
      if (|(info & OP_LH))  result = {{48{shifted[15]}}, shifted[15:0]};
      if (|(info & OP_LW))  result = {{32{shifted[31]}}, shifted[31:0]};
      if (|(info & OP_LD))  result = shifted;
      if (|(info & OP_LBU)) result = {56'd0, shifted[7:0]};
      if (|(info & OP_LHU)) result = {48'd0, shifted[15:0]};
      if (|(info & OP_LWU)) result = {32'd0, shifted[31:0]};
   end

endmodule

// File: rtl/memory_access.sv
// Memory stage: accepts one instruction at a time, runs the data-memory
// request/grant/rvalid handshake and holds the result until writeback takes it.
module memory_access
   import memory_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              regM_i_valid,
   input  logic [INFO_W-1:0] regM_i_load_store_info,
   input  logic [63:0]       regM_i_alu_result,
   input  logic [63:0]       regM_i_regdata2,
   input  logic [63:0]       regM_i_pc,
   input  logic [63:0]       regM_i_commit_pre_pc,
   output logic              memory_o_ready,
   output logic              dmem_o_req,
   output logic              dmem_o_we,
   output logic [63:0]       dmem_o_addr,
   output logic [63:0]       dmem_o_wdata,
   output logic [7:0]        dmem_o_wstrb,
   input  logic              dmem_i_gnt,
   input  logic              dmem_i_rvalid,
   input  logic [63:0]       dmem_i_rdata,
   output logic              memory_o_valid,
   output logic [63:0]       memory_o_result,
   output logic              memory_o_misalign,
   output logic [63:0]       memory_o_pc,
   output logic [63:0]       memory_o_commit_pre_pc,
   input  logic              wb_i_ready
);

   state_t            state;
   state_t            next_state;
   state_t            accept_target;
   logic              accept;
   logic              is_mem_op;
   logic              misaligned_op;

   logic [63:0]       addr_q;
   logic [INFO_W-1:0] info_q;
   logic [63:0]       pc_q;
   logic [63:0]       commit_pre_pc_q;
   logic              we_q;
   logic [7:0]        wstrb_q;
   logic [63:0]       wdata_q;
   logic [63:0]       result_q;
   logic              misalign_q;
   logic [63:0]       load_result;

   load_extend u_load_extend (
      .info    (info_q),
      .addr_lo (addr_q[2:0]),
      .rdata   (dmem_i_rdata),
      .result  (load_result)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= next_state;
   end

   // An accept in DONE overrides the retire so back-to-back ops see no bubble.
   always_comb begin
      next_state     = state;
      is_mem_op      = |regM_i_load_store_info;
      misaligned_op  = is_misaligned(regM_i_load_store_info, regM_i_alu_result[2:0]);
      accept_target  = (!is_mem_op || misaligned_op) ? ST_DONE : ST_REQ;
      memory_o_ready = (state == ST_IDLE) || ((state == ST_DONE) && wb_i_ready);
      accept         = regM_i_valid && memory_o_ready;
      unique case (state)
         ST_REQ:  if (dmem_i_gnt)    next_state = we_q ? ST_DONE : ST_WAIT;
         ST_WAIT: if (dmem_i_rvalid) next_state = ST_DONE;
         ST_DONE: if (wb_i_ready)    next_state = ST_IDLE;
         default: next_state = state;
      endcase
      if (accept) next_state = accept_target;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q          <= '0;
         info_q          <= '0;
         pc_q            <= '0;
         commit_pre_pc_q <= '0;
         we_q            <= 1'b0;
         wstrb_q         <= '0;
         wdata_q         <= '0;
         result_q        <= '0;
         misalign_q      <= 1'b0;
      end else if (accept) begin
         addr_q          <= regM_i_alu_result;
         info_q          <= regM_i_load_store_info;
         pc_q            <= regM_i_pc;
         commit_pre_pc_q <= regM_i_commit_pre_pc;
         we_q            <= is_store(regM_i_load_store_info) && !misaligned_op;
         wstrb_q         <= store_wstrb(regM_i_load_store_info, regM_i_alu_result[2:0]);
         wdata_q         <= store_wdata(regM_i_load_store_info, regM_i_regdata2);
         result_q        <= is_mem_op ? 64'd0 : regM_i_alu_result;
         misalign_q      <= misaligned_op;
      end else if ((state == ST_WAIT) && dmem_i_rvalid) begin
         result_q        <= load_result;
      end
   end

   assign dmem_o_req             = (state == ST_REQ);
   assign dmem_o_we              = we_q;
   assign dmem_o_addr            = {addr_q[63:3], 3'b000};
   assign dmem_o_wdata           = wdata_q;
   assign dmem_o_wstrb           = wstrb_q;

   assign memory_o_valid         = (state == ST_DONE);
   assign memory_o_result        = result_q;
   assign memory_o_misalign      = misalign_q;
   assign memory_o_pc            = pc_q;
   assign memory_o_commit_pre_pc = commit_pre_pc_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a scoreboard queue holds the expected
// writeback for each accepted op and is drained when memory_o_valid appears.
module tb_memory_access;

   localparam logic [10:0] T_LB  = 11'h400;
   localparam logic [10:0] T_LH  = 11'h200;
   localparam logic [10:0] T_LW  = 11'h100;
   localparam logic [10:0] T_LD  = 11'h080;
   localparam logic [10:0] T_LBU = 11'h040;
   localparam logic [10:0] T_SB  = 11'h008;
   localparam logic [10:0] T_SH  = 11'h004;

   typedef struct {
      string       tag;
      logic [63:0] result;
      logic        misalign;
      logic [63:0] pc;
      logic [63:0] cpc;
      int          latency;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        regM_i_valid;
   logic [10:0] regM_i_load_store_info;
   logic [63:0] regM_i_alu_result;
   logic [63:0] regM_i_regdata2;
   logic [63:0] regM_i_pc;
   logic [63:0] regM_i_commit_pre_pc;
   logic        memory_o_ready;
   logic        dmem_o_req;
   logic        dmem_o_we;
   logic [63:0] dmem_o_addr;
   logic [63:0] dmem_o_wdata;
   logic [7:0]  dmem_o_wstrb;
   logic        dmem_i_gnt;
   logic        dmem_i_rvalid;
   logic [63:0] dmem_i_rdata;
   logic        memory_o_valid;
   logic [63:0] memory_o_result;
   logic        memory_o_misalign;
   logic [63:0] memory_o_pc;
   logic [63:0] memory_o_commit_pre_pc;
   logic        wb_i_ready;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          acc_cyc = 0;
   int          req_cycles = 0;
   int          hs_count = 0;
   int          snap;
   logic [63:0] pc_next = 64'h8000_0000;

   memory_access dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .regM_i_valid           (regM_i_valid),
      .regM_i_load_store_info (regM_i_load_store_info),
      .regM_i_alu_result      (regM_i_alu_result),
      .regM_i_regdata2        (regM_i_regdata2),
      .regM_i_pc              (regM_i_pc),
      .regM_i_commit_pre_pc   (regM_i_commit_pre_pc),
      .memory_o_ready         (memory_o_ready),
      .dmem_o_req             (dmem_o_req),
      .dmem_o_we              (dmem_o_we),
      .dmem_o_addr            (dmem_o_addr),
      .dmem_o_wdata           (dmem_o_wdata),
      .dmem_o_wstrb           (dmem_o_wstrb),
      .dmem_i_gnt             (dmem_i_gnt),
      .dmem_i_rvalid          (dmem_i_rvalid),
      .dmem_i_rdata           (dmem_i_rdata),
      .memory_o_valid         (memory_o_valid),
      .memory_o_result        (memory_o_result),
      .memory_o_misalign      (memory_o_misalign),
      .memory_o_pc            (memory_o_pc),
      .memory_o_commit_pre_pc (memory_o_commit_pre_pc),
      .wb_i_ready             (wb_i_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (dmem_o_req === 1'b1) req_cycles <= req_cycles + 1;
      if (rst_n === 1'b1 && dmem_o_req === 1'b1 && dmem_i_gnt === 1'b1) hs_count <= hs_count + 1;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called at a falling edge; presents one op, pushes its expectation, returns at the next falling edge.
   task automatic applyStimulus(input string tag, input logic [10:0] info, input logic [63:0] addr,
                                input logic [63:0] data, input logic [63:0] exp_result,
                                input logic exp_mis, input int lat);
      exp_t e;
      regM_i_valid           = 1'b1;
      regM_i_load_store_info = info;
      regM_i_alu_result      = addr;
      regM_i_regdata2        = data;
      regM_i_pc              = pc_next;
      regM_i_commit_pre_pc   = pc_next - 64'd4;
      e.tag      = tag;
      e.result   = exp_result;
      e.misalign = exp_mis;
      e.pc       = pc_next;
      e.cpc      = pc_next - 64'd4;
      e.latency  = lat;
      exp_q.push_back(e);
      pc_next = pc_next + 64'd4;
      chk({tag, "_ready"}, memory_o_ready, 1'b1);
      @(posedge clk);
      #1 acc_cyc = cyc;
      @(negedge clk);
      regM_i_valid = 1'b0;
   endtask

   task automatic checkOutput();
      exp_t e;
      int   budget;
      budget = 0;
      while (memory_o_valid !== 1'b1 && budget < 20) begin
         @(posedge clk);
         @(negedge clk);
         budget++;
      end
      chk("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({e.tag, "_valid"},    memory_o_valid, 1'b1);
         chk({e.tag, "_latency"},  cyc - acc_cyc + 1, e.latency);
         chk({e.tag, "_result"},   memory_o_result, e.result);
         chk({e.tag, "_misalign"}, memory_o_misalign, e.misalign);
         chk({e.tag, "_pc"},       memory_o_pc, e.pc);
         chk({e.tag, "_cpc"},      memory_o_commit_pre_pc, e.cpc);
      end
   endtask

   // Holds gnt low for 'delay' cycles, checking the request stays put, then grants once.
   task automatic busGrant(input string tag, input int delay, input logic [63:0] addr,
                           input logic we, input logic [7:0] strb, input logic [63:0] wdata);
      for (int i = 0; i <= delay; i++) begin
         chk({tag, "_reqfields"}, {dmem_o_req, dmem_o_we, dmem_o_addr, dmem_o_wstrb, dmem_o_wdata},
             {1'b1, we, addr, strb, wdata});
         if (i < delay) begin
            @(posedge clk);
            @(negedge clk);
         end
      end
      dmem_i_gnt = 1'b1;
      @(posedge clk);
      @(negedge clk);
      dmem_i_gnt = 1'b0;
   endtask

   task automatic busRvalid(input logic [63:0] rdata);
      dmem_i_rvalid = 1'b1;
      dmem_i_rdata  = rdata;
      @(posedge clk);
      @(negedge clk);
      dmem_i_rvalid = 1'b0;
      dmem_i_rdata  = 64'h5A5A_5A5A_5A5A_5A5A;
   endtask

   task automatic idleCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n                  = 1'b0;
      regM_i_valid           = 1'b0;
      regM_i_load_store_info = '0;
      regM_i_alu_result      = '0;
      regM_i_regdata2        = '0;
      regM_i_pc              = '0;
      regM_i_commit_pre_pc   = '0;
      dmem_i_gnt             = 1'b0;
      dmem_i_rvalid          = 1'b0;
      dmem_i_rdata           = '0;
      wb_i_ready             = 1'b1;

      repeat (3) @(negedge clk);
      chk("rst_valid",  memory_o_valid, 1'b0);
      chk("rst_req",    dmem_o_req, 1'b0);
      chk("rst_ready",  memory_o_ready, 1'b1);
      chk("rst_result", memory_o_result, 64'd0);
      chk("rst_dmem",   {dmem_o_we, dmem_o_addr, dmem_o_wstrb, dmem_o_wdata}, '0);
      rst_n = 1'b1;
      idleCycle();
      chk("post_rst_ready", memory_o_ready, 1'b1);

      // Non-memory pass-through, then a second one accepted straight out of DONE.
      applyStimulus("alu0", 11'h000, 64'hDEAD_BEEF_0000_1234, 64'h0, 64'hDEAD_BEEF_0000_1234, 1'b0, 1);
      checkOutput();
      applyStimulus("alu1", 11'h000, 64'h0000_0000_0000_0001, 64'h0, 64'h1, 1'b0, 1);
      checkOutput();
      idleCycle();

      applyStimulus("lw", T_LW, 64'h1004, 64'h0, 64'hFFFF_FFFF_8000_0001, 1'b0, 3);
      busGrant("lw", 0, 64'h1000, 1'b0, 8'h00, 64'h0);
      busRvalid(64'h8000_0001_0000_0000);
      checkOutput();
      idleCycle();

      applyStimulus("lbu", T_LBU, 64'h2007, 64'h0, 64'h0000_0000_0000_00AB, 1'b0, 3);
      busGrant("lbu", 0, 64'h2000, 1'b0, 8'h00, 64'h0);
      busRvalid(64'hAB00_0000_0000_0000);
      checkOutput();
      idleCycle();

      applyStimulus("sh", T_SH, 64'h3002, 64'h0000_0000_0000_1234, 64'h0, 1'b0, 2);
      busGrant("sh", 0, 64'h3000, 1'b1, 8'h0C, 64'h1234_1234_1234_1234);
      checkOutput();
      idleCycle();

      // Misaligned doubleword never reaches the bus; a store follows without a bubble.
      snap = req_cycles;
      applyStimulus("ld_mis", T_LD, 64'h4004, 64'h0, 64'h0, 1'b1, 1);
      checkOutput();
      chk("ld_mis_noreq", req_cycles - snap, 0);
      applyStimulus("sb", T_SB, 64'h7005, 64'hFFFF_FFA5, 64'h0, 1'b0, 2);
      busGrant("sb", 0, 64'h7000, 1'b1, 8'h20, 64'hA5A5_A5A5_A5A5_A5A5);
      checkOutput();
      idleCycle();

      applyStimulus("lh", T_LH, 64'h6006, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 3);
      busGrant("lh", 0, 64'h6000, 1'b0, 8'h00, 64'h0);
      busRvalid(64'h8001_0000_0000_0000);
      checkOutput();
      idleCycle();

      // Grant withheld 5 cycles, then writeback stalls 3 cycles with the result held.
      snap = hs_count;
      applyStimulus("hold", T_LW, 64'h5008, 64'h0, 64'hFFFF_FFFF_FEDC_BA98, 1'b0, 11);
      busGrant("hold", 5, 64'h5008, 1'b0, 8'h00, 64'h0);
      wb_i_ready = 1'b0;
      busRvalid(64'h1111_2222_FEDC_BA98);
      for (int i = 0; i < 3; i++) begin
         chk("hold_valid",  memory_o_valid, 1'b1);
         chk("hold_result", memory_o_result, 64'hFFFF_FFFF_FEDC_BA98);
         chk("hold_noreq",  dmem_o_req, 1'b0);
         idleCycle();
      end
      wb_i_ready = 1'b1;
      checkOutput();
      chk("hold_one_handshake", hs_count - snap, 1);
      idleCycle();

      // Reset while waiting for read data; the late rvalid must be ignored.
      applyStimulus("rst_mid", T_LB, 64'h5010, 64'h0, 64'h0, 1'b0, 3);
      busGrant("rst_mid", 0, 64'h5010, 1'b0, 8'h00, 64'h0);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", memory_o_valid, 1'b0);
      chk("rst_mid_req",   dmem_o_req, 1'b0);
      chk("rst_mid_ready", memory_o_ready, 1'b1);
      exp_q.delete();
      idleCycle();
      rst_n = 1'b1;
      idleCycle();
      busRvalid(64'hFFFF_FFFF_FFFF_FFFF);
      for (int i = 0; i < 3; i++) begin
         chk("late_rvalid_valid", memory_o_valid, 1'b0);
         chk("late_rvalid_ready", memory_o_ready, 1'b1);
         idleCycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
